s832a_stim_driver: RTL and testbench
====================================

Name: s832a_stim_driver

Overview:
- Drives the s832a sequential controller's 18 primary inputs and compacts its 19 primary outputs.
- An 18-bit LFSR generates the input patterns; a 19-bit MISR compacts the responses.
- A pattern counter and control FSM run a fixed-length session; the final signature is compared against a golden value.
- Sits beside the s832a instance in the self-test wrapper; START/DONE/PASS connect to the wrapper controller.

Parameters:
- NPAT, 256, patterns per session (1..65535).
- SEED, 18'h00001, LFSR load value (nonzero).
- GOLDEN, 19'h00000, expected final signature.

Ports:
- CK  in  1  rising-edge clock.
- RN  in  1  asynchronous active-low reset.
- START  in  1  session request, level-sampled.
- STIM  out  18  to the controller under test: [16:0] = G0..G16, [17] = G18.
- RESP  in  19  from the controller under test, [18:0] = G43,G45,G47,G49,G53,G55,G288,G290,G292,G296,G298,G300,G302,G310,G312,G315,G322,G325,G327 (bit 18 = G43, bit 0 = G327).
- BUSY  out  1  session active.
- DONE  out  1  session complete, result valid.
- PASS  out  1  SIG == GOLDEN, valid while DONE.
- SIG  out  19  current MISR contents.
- PCNT  out  16  pattern index.

Behaviour:
- One clock CK. Reset is asynchronous, active-low (RN).
- All state is registered.
- Reset values: state = IDLE, STIM = 18'h20000 (G18 = 1 holds the controller's state flops clear), LFSR = SEED, SIG = 0, PCNT = 0, BUSY = 0, DONE = 0, PASS = 0.
- LFSR step: next = {lfsr[16:0], lfsr[17] ^ lfsr[10]} (x^18 + x^11 + 1).
- MISR step: next = {misr[17:0], 1'b0} ^ (misr[18] ? 19'h00047 : 0) ^ RESP.
- IDLE:
  - STIM = 18'h20000.
  - START = 1 → INIT.
  - DONE and PASS keep the last session's values.
- INIT (1 cycle):
  - STIM = 18'h20000, so the controller is cleared at the closing edge.
  - At that edge: LFSR ← SEED, SIG ← 0, PCNT ← 0, DONE ← 0, PASS ← 0, STIM ← {1'b0, SEED[16:0]}.
  - Next state → RUN.
- RUN:
  - The pattern for index PCNT is on STIM for the whole cycle; the controller responds combinationally.
  - At the closing edge the MISR absorbs RESP, the LFSR steps, and STIM ← {1'b0, next_lfsr[16:0]}.
  - If PCNT == NPAT-1 → SIGN and STIM ← 18'h20000; otherwise PCNT ← PCNT + 1.
- SIGN (1 cycle): PASS ← (SIG == GOLDEN), DONE ← 1 → DONE_ST.
- DONE_ST:
  - DONE = 1, BUSY = 0, STIM = 18'h20000.
  - START = 1 → INIT (restart); otherwise hold.
- BUSY = 1 in INIT, RUN and SIGN only.
- START is ignored while BUSY = 1.
- Total session: 1 + NPAT + 1 cycles from the START-sampling edge to the DONE rising edge.
- PCNT never wraps, since NPAT ≤ 65535.
- A single-pattern session (NPAT = 1) goes RUN → SIGN after one cycle.
- RN low mid-session: immediate return to reset values. No partial result is kept; DONE = 0.
- START held high continuously causes back-to-back sessions, each separated by DONE_ST for one cycle.

Optional Feature:
- Macro: S832A_STIM_CLEAR_EN.
- When defined: in RUN, STIM[17] = lfsr[17], so G18 is randomized and random mid-sequence clears of the controller are exercised. The MISR equation is unchanged.
- When undefined: STIM[17] = 0 throughout RUN.
- INIT, IDLE and DONE_ST behaviour is identical in both builds.

Test Plan:
- Reset: assert RN = 0 mid-RUN, then release → STIM = 18'h20000, BUSY = 0, DONE = 0, SIG = 0, PCNT = 0 immediately, with no clock edge needed.
- SEED = 1, NPAT = 4, pulse START → RUN cycles show STIM[16:0] = 1, 2, 4, 8 and PCNT = 0, 1, 2, 3. DONE rises 6 edges after the START-sampling edge.
- RESP tied to 0, GOLDEN = 0, NPAT = 256 → SIG = 0, DONE = 1, PASS = 1.
- RESP tied to 19'h00001, NPAT = 3, GOLDEN = 0 → SIG = 1, 3, 7 after successive RUN cycles. Final SIG = 19'h00007, PASS = 0.
- START pulsed during RUN → ignored, PCNT sequence uninterrupted. START in DONE_ST → INIT, DONE drops, SIG re-cleared.
- Connect to the real s832a, NPAT = 256, GOLDEN = signature from the gate-level reference run → PASS = 1. Build with S832A_STIM_CLEAR_EN: STIM[17] toggles during RUN, and PASS = 1 against that build's golden value.

Source files
------------

// File: rtl/s832a_stim_driver.sv
// BIST stimulus driver for s832a: 18-bit LFSR patterns, 19-bit MISR compaction, fixed-length session.
// S832A_STIM_CLEAR_EN: randomize G18 (STIM[17]) during RUN to exercise mid-sequence clears.
module s832a_stim_driver #(
  parameter int unsigned NPAT   = 256,
  parameter logic [17:0] SEED   = 18'h00001,
  parameter logic [18:0] GOLDEN = 19'h00000
) (
  input  logic        CK,
  input  logic        RN,
  input  logic        START,
  output logic [17:0] STIM,
  input  logic [18:0] RESP,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic [18:0] SIG,
  output logic [15:0] PCNT
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_SIGN,
    ST_DONE_ST
  } state_t;

  localparam logic [17:0] LP_STIM_CLR = 18'h20000;
  localparam logic [15:0] LP_LAST     = 16'(NPAT - 1);

  state_t      r_state, w_state_nxt;
  logic [17:0] r_lfsr, w_lfsr_nxt, w_lfsr_step;
  logic [18:0] r_misr, w_misr_nxt, w_misr_step;
  logic [15:0] r_pcnt, w_pcnt_nxt;
  logic [17:0] r_stim, w_stim_nxt;
  logic        r_done, w_done_nxt;
  logic        r_pass, w_pass_nxt;
  logic        w_g18;

  assign w_lfsr_step = {r_lfsr[16:0], r_lfsr[17] ^ r_lfsr[10]};
  assign w_misr_step = {r_misr[17:0], 1'b0} ^ (r_misr[18] ? 19'h00047 : 19'h00000) ^ RESP;

`ifdef S832A_STIM_CLEAR_EN
  assign w_g18 = w_lfsr_step[17];
`else
  assign w_g18 = 1'b0;
`endif

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lfsr_nxt  = r_lfsr;
    w_misr_nxt  = r_misr;
    w_pcnt_nxt  = r_pcnt;
    w_stim_nxt  = r_stim;
    w_done_nxt  = r_done;
    w_pass_nxt  = r_pass;
    case (r_state)
      ST_IDLE: begin
        w_stim_nxt = LP_STIM_CLR;
        if (START) w_state_nxt = ST_INIT;
      end
      ST_INIT: begin
        // G18 is high through this cycle, so the controller is cleared at the closing edge
        w_lfsr_nxt  = SEED;
        w_misr_nxt  = '0;
        w_pcnt_nxt  = '0;
        w_done_nxt  = 1'b0;
        w_pass_nxt  = 1'b0;
        w_stim_nxt  = {1'b0, SEED[16:0]};
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_misr_nxt = w_misr_step;
        w_lfsr_nxt = w_lfsr_step;
        if (r_pcnt == LP_LAST) begin
          w_stim_nxt  = LP_STIM_CLR;
          w_state_nxt = ST_SIGN;
        end else begin
          w_stim_nxt = {w_g18, w_lfsr_step[16:0]};
          w_pcnt_nxt = r_pcnt + 16'd1;
        end
      end
      ST_SIGN: begin
        w_pass_nxt  = (r_misr == GOLDEN);
        w_done_nxt  = 1'b1;
        w_stim_nxt  = LP_STIM_CLR;
        w_state_nxt = ST_DONE_ST;
      end
      ST_DONE_ST: begin
        w_stim_nxt = LP_STIM_CLR;
        if (START) w_state_nxt = ST_INIT;
      end
      default: begin
        w_stim_nxt  = LP_STIM_CLR;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_lfsr <= SEED;
      r_misr <= '0;
      r_pcnt <= '0;
      r_stim <= LP_STIM_CLR;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else begin
      r_lfsr <= w_lfsr_nxt;
      r_misr <= w_misr_nxt;
      r_pcnt <= w_pcnt_nxt;
      r_stim <= w_stim_nxt;
      r_done <= w_done_nxt;
      r_pass <= w_pass_nxt;
    end
  end

  assign STIM = r_stim;
  assign BUSY = (r_state == ST_INIT) || (r_state == ST_RUN) || (r_state == ST_SIGN);
  assign DONE = r_done;
  assign PASS = r_pass;
  assign SIG  = r_misr;
  assign PCNT = r_pcnt;

endmodule

// File: tb/tb_s832a_stim_driver.sv
// Directed bench: NPAT=4 instance for pattern/MISR/restart/reset, NPAT=1 instance for the single-pattern edge.
module tb_s832a_stim_driver;

  logic        ck;
  logic        rn;

  logic        start_a;
  logic [18:0] resp_a;
  logic [17:0] stim_a;
  logic        busy_a, done_a, pass_a;
  logic [18:0] sig_a;
  logic [15:0] pcnt_a;

  logic        start_b;
  logic [18:0] resp_b;
  logic [17:0] stim_b;
  logic        busy_b, done_b, pass_b;
  logic [18:0] sig_b;
  logic [15:0] pcnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  s832a_stim_driver #(.NPAT(4), .SEED(18'h00001), .GOLDEN(19'h00000)) u_dut_a (
    .CK(ck), .RN(rn), .START(start_a), .STIM(stim_a), .RESP(resp_a),
    .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .SIG(sig_a), .PCNT(pcnt_a)
  );

  s832a_stim_driver #(.NPAT(1), .SEED(18'h2A5A5), .GOLDEN(19'h00005)) u_dut_b (
    .CK(ck), .RN(rn), .START(start_b), .STIM(stim_b), .RESP(resp_b),
    .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .SIG(sig_b), .PCNT(pcnt_b)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    rn      = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    resp_a  = 19'h0;
    resp_b  = 19'h00005;
    repeat (2) @(negedge ck);

    check("rst_stim", 32'(stim_a), 32'h20000);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_pass", 32'(pass_a), 0);
    check("rst_sig",  32'(sig_a),  0);
    check("rst_pcnt", 32'(pcnt_a), 0);
    check("rst_stim_b", 32'(stim_b), 32'h20000);
    rn = 1'b1;
    @(negedge ck);
    check("idle_busy", 32'(busy_a), 0);

    // Session 1: RESP = 0, walking-one patterns
    start_a = 1'b1;
    @(negedge ck);
    check("init_busy", 32'(busy_a), 1);
    check("init_stim", 32'(stim_a), 32'h20000);
    start_a = 1'b0;
    @(negedge ck);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("s1_stim%0d", i), 32'(stim_a), 32'(1 << i));
      check($sformatf("s1_pcnt%0d", i), 32'(pcnt_a), 32'(i));
      check($sformatf("s1_busy%0d", i), 32'(busy_a), 1);
      @(negedge ck);
    end
    check("s1_sign_stim", 32'(stim_a), 32'h20000);
    check("s1_sign_done", 32'(done_a), 0);
    check("s1_sign_busy", 32'(busy_a), 1);
    @(negedge ck);
    check("s1_done", 32'(done_a), 1);
    check("s1_pass", 32'(pass_a), 1);
    check("s1_sig",  32'(sig_a),  0);
    check("s1_busy", 32'(busy_a), 0);
    @(negedge ck);
    check("s1_hold_done", 32'(done_a), 1);
    check("s1_hold_busy", 32'(busy_a), 0);

    // Session 2: restart from DONE_ST, RESP = 1, START pulse during RUN
    resp_a  = 19'h00001;
    start_a = 1'b1;
    @(negedge ck);
    check("s2_init_busy", 32'(busy_a), 1);
    check("s2_init_done_kept", 32'(done_a), 1);
    start_a = 1'b0;
    @(negedge ck);
    check("s2_done_clr", 32'(done_a), 0);
    check("s2_pass_clr", 32'(pass_a), 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("s2_sig%0d", i),  32'(sig_a),  32'((1 << i) - 1));
      check($sformatf("s2_pcnt%0d", i), 32'(pcnt_a), 32'(i));
      start_a = (i == 1);
      @(negedge ck);
    end
    start_a = 1'b0;
    check("s2_sign_sig", 32'(sig_a), 32'h0000F);
    @(negedge ck);
    check("s2_done", 32'(done_a), 1);
    check("s2_pass", 32'(pass_a), 0);
    check("s2_sig",  32'(sig_a),  32'h0000F);

    // START held: DONE_ST lasts one cycle, then a new session
    start_a = 1'b1;
    @(negedge ck);
    check("b2b_busy", 32'(busy_a), 1);
    @(negedge ck);
    check("b2b_sig0", 32'(sig_a), 0);
    @(negedge ck);
    @(negedge ck);
    check("b2b_sig2", 32'(sig_a),  32'h3);
    check("b2b_pcnt", 32'(pcnt_a), 2);

    // Asynchronous reset mid-RUN
    rn = 1'b0;
    #1;
    check("arst_stim", 32'(stim_a), 32'h20000);
    check("arst_busy", 32'(busy_a), 0);
    check("arst_done", 32'(done_a), 0);
    check("arst_sig",  32'(sig_a),  0);
    check("arst_pcnt", 32'(pcnt_a), 0);
    start_a = 1'b0;
    @(negedge ck);
    rn = 1'b1;
    @(negedge ck);

    // Single-pattern session, STIM[17] masked from SEED
    start_b = 1'b1;
    @(negedge ck);
    start_b = 1'b0;
    @(negedge ck);
    check("b_run_stim", 32'(stim_b), 32'h0A5A5);
    check("b_run_pcnt", 32'(pcnt_b), 0);
    @(negedge ck);
    check("b_sign_sig",  32'(sig_b),  32'h00005);
    check("b_sign_stim", 32'(stim_b), 32'h20000);
    check("b_sign_busy", 32'(busy_b), 1);
    @(negedge ck);
    check("b_done", 32'(done_b), 1);
    check("b_pass", 32'(pass_b), 1);
    check("b_busy", 32'(busy_b), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
